// File: rtl/alu_issue_fifo_pkg.sv
// alu_pkg: opcode and command bundle types shared by the ALU issue path.
package alu_pkg;
    localparam int WIDTH = 8;
    typedef enum logic [1:0] {ADD = 2'b00, GE = 2'b01, SHL = 2'b10, NOR = 2'b11} alu_op_e;
    typedef struct packed {
        alu_op_e            opcode;
        logic [WIDTH-1:0]   first;
        logic [WIDTH-1:0]   second;
    } alu_cmd_t;
endpackage

// File: rtl/alu_issue_fifo_if.sv
// alu_issue_if: producer handshake and ALU issue signals of the issue FIFO.
interface alu_issue_if #(parameter int DEPTH = 4) ();
    import alu_pkg::*;
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [WIDTH-1:0]       in_first_i;
    logic [WIDTH-1:0]       in_second_i;
    logic [1:0]             in_opcode_i;
    logic                   hold_i;
    logic                   valid_o;
    logic [WIDTH-1:0]       first_o;
    logic [WIDTH-1:0]       second_o;
    logic [1:0]             opcode_o;
    logic [$clog2(DEPTH):0] count_o;
    modport master (
        output in_valid_i, in_first_i, in_second_i, in_opcode_i, hold_i,
        input  in_ready_o, valid_o, first_o, second_o, opcode_o, count_o
    );
    modport slave (
        input  in_valid_i, in_first_i, in_second_i, in_opcode_i, hold_i,
        output in_ready_o, valid_o, first_o, second_o, opcode_o, count_o
    );
endinterface

// File: rtl/alu_cmd_mem.sv
// alu_cmd_mem: command storage, one write port and one asynchronous read port.
module alu_cmd_mem
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  alu_cmd_t      wdata,
    input  logic [AW-1:0] raddr,
    output alu_cmd_t      rdata
);
    alu_cmd_t mem [DEPTH];
    always_ff @(posedge clk_i)
        if (we) mem[waddr] <= wdata;
    assign rdata = mem[raddr];
endmodule

// File: rtl/alu_issue_fifo.sv
// alu_issue_fifo: circular command FIFO issuing one registered bundle per cycle
// to the ALU stage, throttled only by hold_i.
module alu_issue_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic        clk_i,
    input logic        rst_ni,
    alu_issue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          push, pop, out_valid;
    alu_cmd_t      wr_cmd, rd_cmd, out_cmd;
    // Pop only sees registered occupancy, so a fresh push into an empty FIFO waits a cycle.
    assign bus.in_ready_o = count != (AW+1)'(DEPTH);
    assign push   = bus.in_valid_i && bus.in_ready_o;
    assign pop    = count != '0 && !bus.hold_i;
    assign wr_cmd = {bus.in_opcode_i, bus.in_first_i, bus.in_second_i};
    alu_cmd_mem #(.DEPTH(DEPTH)) u_mem (
        .clk_i (clk_i),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (wr_cmd),
        .raddr (rd_ptr),
        .rdata (rd_cmd)
    );
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_cmd   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr  <= rd_ptr + 1'b1;
                out_cmd <= rd_cmd;
            end
            out_valid <= pop;
            count     <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    assign bus.valid_o  = out_valid;
    assign bus.first_o  = out_cmd.first;
    assign bus.second_o = out_cmd.second;
    assign bus.opcode_o = out_cmd.opcode;
    assign bus.count_o  = count;
endmodule

// File: tb/tb_alu_issue_fifo.sv
// tb_alu_issue_fifo: directed test of the ALU issue FIFO with a small occupancy/order model.
module tb_alu_issue_fifo;
    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    int   mcnt = 0;
    int   npop = 0;
    logic [17:0] q[$];
    logic [17:0] last = '0;

    always #5 clk = ~clk;

    alu_issue_if #(.DEPTH(4)) bus ();
    alu_issue_fifo #(.DEPTH(4)) dut (.clk_i(clk), .rst_ni(rst_ni), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        bus.in_valid_i  = v;
        bus.in_opcode_i = op;
        bus.in_first_i  = a;
        bus.in_second_i = b;
    endtask

    // One clock edge; ready is checked before the edge, issue/count/data after it.
    task automatic cyc();
        logic acc, pp;
        logic [17:0] cur;
        acc = bus.in_valid_i && mcnt != 4;
        pp  = mcnt != 0 && !bus.hold_i;
        cur = {bus.in_opcode_i, bus.in_first_i, bus.in_second_i};
        chk("ready", 32'(bus.in_ready_o), 32'(mcnt != 4));
        @(posedge clk);
        #1;
        if (pp) begin
            last = q.pop_front();
            npop++;
        end
        if (acc) q.push_back(cur);
        mcnt = mcnt + int'(acc) - int'(pp);
        chk("valid", 32'(bus.valid_o), 32'(pp));
        chk("count", 32'(bus.count_o), 32'(mcnt));
        chk("data", 32'({bus.opcode_o, bus.first_o, bus.second_o}), 32'(last));
    endtask

    initial begin
        int i, guard;
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        bus.hold_i = 1'b0;
        #2;
        chk("rst_valid", 32'(bus.valid_o), 32'd0);
        chk("rst_count", 32'(bus.count_o), 32'd0);
        chk("rst_ready", 32'(bus.in_ready_o), 32'd1);
        chk("rst_data", 32'({bus.opcode_o, bus.first_o, bus.second_o}), 32'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;

        // Single pass: accepted at edge k, issued after edge k+1.
        drive(1'b1, 2'b00, 8'h05, 8'h03);
        cyc();
        chk("sp_count1", 32'(bus.count_o), 32'd1);
        chk("sp_novalid", 32'(bus.valid_o), 32'd0);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        cyc();
        chk("sp_valid", 32'(bus.valid_o), 32'd1);
        chk("sp_first", 32'(bus.first_o), 32'h05);
        chk("sp_second", 32'(bus.second_o), 32'h03);
        chk("sp_count0", 32'(bus.count_o), 32'd0);
        cyc();
        chk("sp_hold_first", 32'(bus.first_o), 32'h05);

        // Fill with hold: fifth push refused.
        bus.hold_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 2'(k), 8'hA0 + 8'(k), 8'h50 + 8'(k));
            cyc();
        end
        chk("fill_ready", 32'(bus.in_ready_o), 32'd0);
        chk("fill_count", 32'(bus.count_o), 32'd4);
        chk("fill_valid", 32'(bus.valid_o), 32'd0);

        // Drain with continuous pushes 0x00..0x0F; 20 bundles issue in order.
        npop = 0;
        bus.hold_i = 1'b0;
        i = 0;
        guard = 0;
        while (i < 16 && guard < 100) begin
            drive(1'b1, 2'(i), 8'(i), ~8'(i));
            if (mcnt != 4) i++;
            cyc();
            guard++;
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        guard = 0;
        while (mcnt != 0 && guard < 30) begin
            cyc();
            guard++;
        end
        chk("drain_issued", 32'(npop), 32'd20);
        chk("drain_last", 32'(bus.first_o), 32'h0F);

        // Full with simultaneous pop: push refused, then accepted next cycle.
        bus.hold_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'b11, 8'hC0 + 8'(k), 8'h0F);
            cyc();
        end
        bus.hold_i = 1'b0;
        drive(1'b1, 2'b10, 8'hD0, 8'hEE);
        cyc();
        chk("full_count3", 32'(bus.count_o), 32'd3);
        chk("full_first", 32'(bus.first_o), 32'hC0);
        cyc();
        chk("full_count_stay", 32'(bus.count_o), 32'd3);
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        guard = 0;
        while (mcnt != 0 && guard < 10) begin
            cyc();
            guard++;
        end
        chk("full_order_last", 32'(bus.first_o), 32'hD0);

        // Hold toggling 1,0,1,0,0 over 3 queued bundles.
        bus.hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'(k + 1), 8'h10 + 8'(k), 8'h20 + 8'(k));
            cyc();
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        cyc();
        chk("ht_v0", 32'(bus.valid_o), 32'd0);
        bus.hold_i = 1'b0;
        cyc();
        chk("ht_v1", 32'(bus.valid_o), 32'd1);
        chk("ht_d1", 32'(bus.first_o), 32'h10);
        bus.hold_i = 1'b1;
        cyc();
        chk("ht_v2", 32'(bus.valid_o), 32'd0);
        chk("ht_d2", 32'(bus.first_o), 32'h10);
        bus.hold_i = 1'b0;
        cyc();
        chk("ht_v3", 32'(bus.valid_o), 32'd1);
        chk("ht_d3", 32'(bus.first_o), 32'h11);
        cyc();
        chk("ht_v4", 32'(bus.valid_o), 32'd1);
        chk("ht_d4", 32'({bus.opcode_o, bus.first_o, bus.second_o}), 32'({2'b11, 8'h12, 8'h22}));

        // Mid-cycle reset with 2 queued and an issue pulse in flight.
        bus.hold_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 2'b01, 8'h70 + 8'(k), 8'h01);
            cyc();
        end
        drive(1'b0, 2'b00, 8'h00, 8'h00);
        bus.hold_i = 1'b0;
        cyc();
        chk("pre_rst_valid", 32'(bus.valid_o), 32'd1);
        chk("pre_rst_count", 32'(bus.count_o), 32'd2);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.valid_o), 32'd0);
        chk("arst_count", 32'(bus.count_o), 32'd0);
        chk("arst_ready", 32'(bus.in_ready_o), 32'd1);
        chk("arst_data", 32'({bus.opcode_o, bus.first_o, bus.second_o}), 32'd0);
        q.delete();
        mcnt = 0;
        last = '0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        for (int k = 0; k < 3; k++) cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_fifo.md
# alu_issue_fifo

Command buffer directly upstream of the registered ALU stage. Accepts {opcode, first, second} operand bundles from the producer under a valid/ready handshake and stores them in a DEPTH-entry circular FIFO. Issues one bundle per cycle to the ALU as a registered single-cycle `valid_o` pulse with operands. Issue is throttled only by `hold_i`, because the ALU stage has no back-pressure.

## Interface
- `WIDTH`, 8: operand width in bits; matches the ALU stage.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `clk_i`  in  1  clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `in_valid_i`  in  1  producer has a bundle.
- `in_ready_o`  out  1  FIFO can accept a bundle.
- `in_first_i`  in  WIDTH  first operand.
- `in_second_i`  in  WIDTH  second operand.
- `in_opcode_i`  in  2  operation code.
- `hold_i`  in  1  suppresses issue this cycle.
- `valid_o`  out  1  issue pulse to the ALU `valid_i`.
- `first_o`  out  WIDTH  issued first operand.
- `second_o`  out  WIDTH  issued second operand.
- `opcode_o`  out  2  issued opcode.
- `count_o`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.

## Operation
- Push occurs when `in_valid_i && in_ready_o`. The bundle is written at `wr_ptr`, and `wr_ptr` increments modulo DEPTH.
- `in_ready_o = (count != DEPTH)`. It is combinational from registered count only and does not depend on `in_valid_i`.
- No push bypass when full: a push is refused while `count == DEPTH`, even if a pop occurs in the same cycle.
- Pop occurs when `count != 0 && !hold_i`. At the edge, the head entry is registered into `first_o`/`second_o`/`opcode_o`, `valid_o <= 1`, and `rd_ptr` increments modulo DEPTH.
- No pop: `valid_o <= 0`. Data outputs hold their last issued value.
- Count update per edge: +1 for push only, −1 for pop only, unchanged for both or neither.
- An entry pushed into an empty FIFO is not visible to the pop logic in the same cycle. There is no empty bypass.
- The FIFO never reorders, drops, or duplicates bundles. Issue order equals accept order.
- Opcode values pass through unmodified: 00 add, 01 ≥ compare, 10 shift-left, 11 nor. All four are legal, and the block does no decoding.
- Pointers are `$clog2(DEPTH)` bits wide, and wrap from DEPTH−1 to 0.

## Timing
- Reset state (async assert, sync release): `rd_ptr`, `wr_ptr` and count = 0; `valid_o` = 0; `first_o`, `second_o`, `opcode_o` = 0; `in_ready_o` = 1 (follows from count = 0).
- Storage array is not reset. Reset mid-operation discards all queued bundles immediately. Any `valid_o` pulse in flight is cleared asynchronously.
- Latency: a bundle accepted at edge k into an empty FIFO with `hold_i` low drives `valid_o` = 1 after edge k+1.
- Throughput: one push and one pop per cycle, sustained indefinitely when 0 < count < DEPTH.
- `hold_i` is sampled at the edge. If `hold_i` is high at edge k, `valid_o` is 0 after edge k.

## Structure
- Shared package `alu_pkg`:
  - opcode enum `alu_op_e` (ADD = 2'b00, GE = 2'b01, SHL = 2'b10, NOR = 2'b11);
  - packed struct `alu_cmd_t` {opcode, first, second}, parameterised via a WIDTH localparam default of 8.
- One sub-module, `alu_cmd_mem`: a DEPTH×`alu_cmd_t` register array with one write port and one asynchronous read port.
- Pointer, count and handshake logic live in `alu_issue_fifo`.

## Test plan
- **Reset:** assert `rst_ni` = 0 mid-clock with 2 entries queued. Required: `valid_o`, `count_o` and data outputs = 0 immediately; `in_ready_o` = 1; no stale issue after release.
- **Single pass:** push {op = 00, first = 8'h05, second = 8'h03} at edge k with `hold_i` = 0. Required: `valid_o` = 1 with the same values only after edge k+1; `count_o` 1→0.
- **Fill with hold:** `hold_i` = 1; push 5 bundles back-to-back with DEPTH = 4. Required: `in_ready_o` = 0 after the 4th; 5th not accepted; `count_o` = 4; `valid_o` stays 0.
- **Drain order and wrap:** release hold and push continuously with incrementing `first` 0x00..0x0F (20 bundles). Required: `valid_o` issues 0x00..0x0F in order with no gaps or duplicates; pointers wrap cleanly.
- **Full, simultaneous pop:** at `count_o` = 4 with `hold_i` = 0 and `in_valid_i` = 1. Required: no push that cycle; count → 3; push accepted next cycle; count stays 3.
- **Hold toggling:** queue 3 bundles, then apply `hold_i` pattern 1,0,1,0,0. Required: `valid_o` pattern 0,1,0,1,1; data outputs hold between pulses.
